// File: rtl/async_edge_sync_bank.sv
// ---------------------------------------------------------------------------
// async_edge_sync_bank
//
// Purpose
//   A bank of independent channels that bring asynchronous pins or slow
//   emulated strobes (PHI2, R/W, IRQ, NMI, RDY, ...) into the sys_clock
//   domain. Each channel has:
//     * an N-stage synchroniser
//     * an optional glitch filter
//     * registered, one-cycle rising/falling edge pulses
//   Slow legacy strobes can then be handled as data rather than as clocks.
//
// Parameters
//   CHANNELS      number of independent channels (>= 1)
//   SYNC_STAGES   synchroniser flops per channel (>= 2)
//   FILTER_CYCLES consecutive synchronised samples of a new level needed
//                 before that level is accepted; 0 bypasses the filter
//
// Optional feature
//   ASYNC_EDGE_STICKY_EN : when defined, adds sticky per-channel event flags
//   (rise_pending / fall_pending) and a write-one-to-clear input
//   (clear_pending). When undefined, these ports and their logic are absent.
//
// Ports
//   sys_clock     in   system clock
//   reset         in   asynchronous, active-high reset
//   async_in      in   [CHANNELS] asynchronous inputs
//   clear_pending in   [CHANNELS] W1C for the pending flags (sticky build only)
//   rise_pending  out  [CHANNELS] sticky rising-event flags (sticky build only)
//   fall_pending  out  [CHANNELS] sticky falling-event flags (sticky build only)
//   level         out  [CHANNELS] filtered, synchronised level
//   rising_edge   out  [CHANNELS] one-cycle pulse on an accepted 0->1
//   falling_edge  out  [CHANNELS] one-cycle pulse on an accepted 1->0
//   any_edge      out  OR of every rising_edge and falling_edge bit
//
// Timing
//   If async_in is first sampled high at edge k, then level and rising_edge
//   are high after edge k + SYNC_STAGES + max(FILTER_CYCLES,1) - 1.
//   level, rising_edge and falling_edge all update on the same edge.
//   any_edge is combinational from the registered pulses, so it adds no
//   latency.
//
// Interface semantics
//   No handshake. Every output is a per-cycle level or pulse. A pulse is
//   valid for exactly the one sys_clock cycle in which it is high.
// ---------------------------------------------------------------------------
module async_edge_sync_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic                sys_clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] async_in,
`ifdef ASYNC_EDGE_STICKY_EN
  input  logic [CHANNELS-1:0] clear_pending,
  output logic [CHANNELS-1:0] rise_pending,
  output logic [CHANNELS-1:0] fall_pending,
`endif
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rising_edge,
  output logic [CHANNELS-1:0] falling_edge,
  output logic                any_edge
);

  // -------------------------------------------------------------------------
  // Synchroniser.
  // Row 0 samples async_in. The last row is the synchronised value.
  // One packed row per stage lets the whole bank shift as a single vector.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_d;
  logic [CHANNELS-1:0]                  sync_w;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Level and edge registers
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rising_q;
  logic [CHANNELS-1:0] rising_d;
  logic [CHANNELS-1:0] falling_q;
  logic [CHANNELS-1:0] falling_d;

  // -------------------------------------------------------------------------
  // Glitch filter.
  // level_d is produced here, either straight from the synchroniser or
  // through a per-channel run-length counter.
  // -------------------------------------------------------------------------
  generate
    if (FILTER_CYCLES == 0) begin : g_bypass

      always_comb begin
        level_d = sync_w;
      end

    end else begin : g_filter

      localparam int CW = $clog2(FILTER_CYCLES + 1);
      // Count value at which the Nth consecutive differing sample arrives.
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

      logic [CHANNELS-1:0][CW-1:0] cnt_q;
      logic [CHANNELS-1:0][CW-1:0] cnt_d;

      // The counter holds how many consecutive samples so far have differed
      // from the accepted level. Any sample that agrees with the level
      // discards the run, so pulses shorter than FILTER_CYCLES never reach
      // the level register.
      always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < CHANNELS; i++) begin
          if (sync_w[i] == level_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = sync_w[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end

      always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

    end
  endgenerate

  // -------------------------------------------------------------------------
  // Edge detection.
  // Edges are taken from the level about to be registered, so a pulse lines
  // up with the cycle in which the new level first appears. A channel's level
  // moves only one way per cycle, so its rising and falling pulses can never
  // be high together.
  // -------------------------------------------------------------------------
  always_comb begin
    rising_d  = level_d & ~level_q;
    falling_d = ~level_d & level_q;
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      rising_q  <= '0;
      falling_q <= '0;
    end else begin
      level_q   <= level_d;
      rising_q  <= rising_d;
      falling_q <= falling_d;
    end
  end

  assign level        = level_q;
  assign rising_edge  = rising_q;
  assign falling_edge = falling_q;
  assign any_edge     = |(rising_q | falling_q);

`ifdef ASYNC_EDGE_STICKY_EN
  // -------------------------------------------------------------------------
  // Sticky event flags.
  // A flag sets in the cycle after its edge pulse. A clear that arrives in
  // the same cycle as the pulse loses, so no event is dropped by a
  // software clear that races a new edge.
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] rise_pend_q;
  logic [CHANNELS-1:0] rise_pend_d;
  logic [CHANNELS-1:0] fall_pend_q;
  logic [CHANNELS-1:0] fall_pend_d;

  always_comb begin
    rise_pend_d = rising_q  | (rise_pend_q & ~clear_pending);
    fall_pend_d = falling_q | (fall_pend_q & ~clear_pending);
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      rise_pend_q <= '0;
      fall_pend_q <= '0;
    end else begin
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
    end
  end

  assign rise_pending = rise_pend_q;
  assign fall_pending = fall_pend_q;
`endif

endmodule
